// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES chunks,
// one chunk resolved per stage, with a single global stall driven by the output handshake.

module pipe_addsub_chunk #(
    parameter int C = 8
) (
    input  logic [C-1:0] a_c,
    input  logic [C-1:0] b_c,
    input  logic         c_in,
    output logic [C-1:0] s_c,
    output logic         c_out
);
    logic [C:0] t;

    always_comb begin
        t     = {1'b0, a_c} + {1'b0, b_c} + {{C{1'b0}}, c_in};
        s_c   = t[C-1:0];
        c_out = t[C];
    end
endmodule

module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int C = WIDTH / STAGES;

    // *_q: stage registers; *_d: what stage k consumes; res_n/c_n: what stage k produces
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, res_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0] a_d, b_d, res_d, res_n;
    logic [STAGES-1:0]            c_d;
    logic [C-1:0]                 chunk_s [STAGES];
    logic                         c_n     [STAGES];
    logic                         en;
    logic                         ovf_n;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = res_q[STAGES-1];

    always_comb begin
        a_d      = '0;
        b_d      = '0;
        res_d    = '0;
        c_d      = '0;
        a_d[0]   = a;
        b_d[0]   = sub ? ~b : b;
        c_d[0]   = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            res_d[k] = res_q[k-1];
            c_d[k]   = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        pipe_addsub_chunk #(.C(C)) u_chunk (
            .a_c   (a_d[k][k*C +: C]),
            .b_c   (b_d[k][k*C +: C]),
            .c_in  (c_d[k]),
            .s_c   (chunk_s[k]),
            .c_out (c_n[k])
        );
    end

    always_comb begin
        res_n = res_d;
        for (int k = 0; k < STAGES; k++)
            res_n[k][k*C +: C] = chunk_s[k];
    end

    // The top operand bits are still carried into the last stage, so overflow is resolved there
    assign ovf_n = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
                   (res_n[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (en) begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_n;
            for (int k = 0; k < STAGES; k++)
                c_q[k] <= c_n[k];
            cout     <= c_n[STAGES-1];
            overflow <= ovf_n;
            zero     <= (res_n[STAGES-1] == '0);
        end
    end

    // Last-stage operand/carry copies and already-consumed low chunks are never read
    logic unused_pipe;
    assign unused_pipe = ^{a_q, b_q, c_q};
endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined adder/subtractor with valid/ready handshakes and status flags, the multi-cycle successor to the single-cycle combinational `adder`. The WIDTH-bit carry chain is split into STAGES equal chunks, one chunk resolved per pipeline stage, so wide operands close timing at high clock rates. It serves the execute datapath and long-width arithmetic such as address/counter math, sustaining one operation per cycle.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth and carry-chain chunk count; must divide WIDTH, 1 ≤ STAGES ≤ WIDTH; chunk width C = WIDTH/STAGES.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of MSB.
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.

## Operation
- Transfer in: in_valid && in_ready on a rising edge. Transfer out: out_valid && out_ready on a rising edge.
- Effective operands: b_eff = sub ? ~b : b; c0 = cin ^ sub.
  - add: a + b + cin.
  - sub: a − b − cin, computed as a + ~b + ~cin.
- cout is the raw adder carry. For sub, cout=1 means no borrow.
- overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..STAGES−1) adds chunk bits [k·C +: C] using the carry registered by stage k−1 (c0 for k=0).
- Stage registers carry:
  - the finished lower chunks;
  - the unprocessed upper a / b_eff chunks;
  - the inter-chunk carry;
  - a valid bit.
- Chunk 0 is computed combinationally from the inputs ahead of the first register.
- Flags (cout, overflow, zero) are computed in the last stage and registered with sum.
- Global advance: en = !out_valid || out_ready.
  - When en=1, every stage register loads from its predecessor; stage 0 loads the inputs with valid = in_valid.
  - When en=0, all registers hold.
  - in_ready = en, combinational from out_valid/out_ready only; no dependence on in_valid.
- Bubbles propagate as invalid slots and are not collapsed. Results leave strictly in issue order; none are dropped or duplicated.
- Reset (async assert, any time, including mid-operation):
  - all valid bits and data/flag registers clear to 0;
  - out_valid=0, sum=0, cout=0, overflow=0, zero=0;
  - in_ready=1 once reset is released;
  - in-flight operations are discarded.
- STAGES=1: a single registered full-width adder with the same handshake.

## Timing
- Latency: an operation accepted on edge t is presented (out_valid=1) after edge t+STAGES−1, given en=1 throughout. Each cycle with en=0 adds one cycle.
- Throughput: 1 op/cycle while out_ready=1.
- While out_valid=1 && out_ready=0:
  - sum, cout, overflow and zero stay stable;
  - in_ready=0;
  - a and b are ignored.
- Simultaneous out transfer and in transfer on the same edge is legal and required for full throughput.
- Operand inputs only need to be valid when in_valid=1. No combinational path from in_valid, a, b, cin or sub to any output.

## Test plan
- Reset: rst_n=0 with random inputs → out_valid=0, sum=0, flags 0, in_ready=1 after release. WIDTH=32, STAGES=4 unless noted.
- Add wrap: a=FFFFFFFF, b=00000001, cin=0, sub=0 → after 4 edges: sum=00000000, cout=1, zero=1, overflow=0. Then a=7FFFFFFF, b=1 → sum=80000000, overflow=1, cout=0.
- Subtract/borrow: a=5, b=7, sub=1, cin=0 → sum=FFFFFFFE, cout=0, overflow=0. With a=5, b=5, cin=1 → sum=FFFFFFFF, cout=0. Then a=80000000, b=1, sub=1 → sum=7FFFFFFF, overflow=1.
- Throughput/backpressure: issue 8 back-to-back ops with out_ready=1 → first result after edge 4, then one per cycle, in order. Then drop out_ready for 3 cycles mid-stream → outputs frozen, in_ready=0, all 8 results eventually delivered exactly once.
- Reset mid-flight: 3 ops in flight, pulse rst_n low for 1 cycle between edges → out_valid falls immediately and none of the 3 results ever appear.
- Random regression: 10000 ops, seed 1, random in_valid/out_ready, at STAGES ∈ {1, 4, 32} and WIDTH ∈ {8, 32, 64} → scoreboard matches a behavioural model (sum, cout, overflow, zero) with 0 errors.
